// File: rtl/apb_gpio_lock_ctrl.sv
// rtl/apb_gpio_lock_ctrl.sv - APB GPIO controller with key-armed sticky per-pin locks
module apb_gpio_lock_ctrl #(
    parameter int               NGPIO      = 32,
    parameter int               ADDR_W     = 12,
    parameter logic [NGPIO-1:0] LOCK_RESET = '0,
    parameter logic [31:0]      KEY1       = 32'h5A5A_0001,
    parameter logic [31:0]      KEY2       = 32'hA5A5_0002
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [31:0]       PWDATA,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    input  logic [NGPIO-1:0]  gpio_in,
    output logic [NGPIO-1:0]  gpio_out,
    output logic [NGPIO-1:0]  gpio_dir,
    output logic [NGPIO-1:0]  gpio_lock
);

    typedef enum logic [1:0] {S_IDLE, S_STAGE1, S_ARMED} state_t;

    localparam logic [ADDR_W-1:0] DEC_MASK = ADDR_W'(28);

    logic [NGPIO-1:0] r_dir, r_out, r_lock, r_sync1, r_sync2;
    logic             r_viol;
    logic [7:0]       r_vcnt;
    state_t           r_state, w_state_nxt;

    logic             w_acc, w_wr, w_mapped;
    logic [2:0]       w_idx;
    logic [NGPIO-1:0] w_wd;
    logic             w_wr_dir, w_wr_out, w_wr_in, w_wr_lock, w_wr_key, w_wr_status;
    logic             w_armed, w_stage1, w_lock_set, w_key_err;
    logic             w_dir_viol, w_out_viol, w_ro_err, w_err;
    logic [31:0]      w_rdata, w_dir32, w_out32, w_in32, w_lock32;

    assign w_acc    = PSEL & PENABLE;
    assign w_wr     = w_acc & PWRITE;
    assign w_idx    = PADDR[4:2];
    assign w_mapped = ((PADDR & ~DEC_MASK) == '0) && (w_idx <= 3'd5);
    assign w_wd     = PWDATA[NGPIO-1:0];

    assign w_wr_dir    = w_wr & w_mapped & (w_idx == 3'd0);
    assign w_wr_out    = w_wr & w_mapped & (w_idx == 3'd1);
    assign w_wr_in     = w_wr & w_mapped & (w_idx == 3'd2);
    assign w_wr_lock   = w_wr & w_mapped & (w_idx == 3'd3);
    assign w_wr_key    = w_wr & w_mapped & (w_idx == 3'd4);
    assign w_wr_status = w_wr & w_mapped & (w_idx == 3'd5);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_acc) begin
            case (r_state)
                S_IDLE:   if (w_wr_key && PWDATA == KEY1) w_state_nxt = S_STAGE1;
                S_STAGE1: w_state_nxt = (w_wr_key && PWDATA == KEY2) ? S_ARMED : S_IDLE;
                default:  w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Any access that breaks the KEY1/KEY2/LOCK sequence is a key error
    always_comb begin
        w_armed    = (r_state == S_ARMED);
        w_stage1   = (r_state == S_STAGE1);
        w_lock_set = w_armed & w_wr_lock;
        w_key_err  = 1'b0;
        if (w_acc) begin
            case (r_state)
                S_IDLE:   w_key_err = w_wr_lock;
                S_STAGE1: w_key_err = !(w_wr_key && PWDATA == KEY2);
                S_ARMED:  w_key_err = !w_wr_lock;
                default:  w_key_err = 1'b0;
            endcase
        end
    end

    assign w_dir_viol = w_wr_dir & (|((w_wd ^ r_dir) & r_lock));
    assign w_out_viol = w_wr_out & (|((w_wd ^ r_out) & r_lock));
    assign w_ro_err   = w_wr_in | (w_wr_status & (|(PWDATA & ~32'h0000_0004)));
    assign w_err      = w_acc & (~w_mapped | w_ro_err | w_key_err | w_dir_viol | w_out_viol);

    always_comb begin
        w_dir32  = '0;
        w_out32  = '0;
        w_in32   = '0;
        w_lock32 = '0;
        w_dir32[NGPIO-1:0]  = r_dir;
        w_out32[NGPIO-1:0]  = r_out;
        w_in32[NGPIO-1:0]   = r_sync2;
        w_lock32[NGPIO-1:0] = r_lock;
        w_rdata = '0;
        if (w_acc && !PWRITE && w_mapped) begin
            case (w_idx)
                3'd0:    w_rdata = w_dir32;
                3'd1:    w_rdata = w_out32;
                3'd2:    w_rdata = w_in32;
                3'd3:    w_rdata = w_lock32;
                3'd5:    w_rdata = {16'h0, r_vcnt, 5'h0, r_viol, w_stage1, w_armed};
                default: w_rdata = '0;
            endcase
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_dir   <= '0;
            r_out   <= '0;
            r_lock  <= LOCK_RESET;
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_viol  <= 1'b0;
            r_vcnt  <= 8'h00;
        end else begin
            r_sync1 <= gpio_in;
            r_sync2 <= r_sync1;
            if (w_wr_dir)   r_dir  <= (r_dir & r_lock) | (w_wd & ~r_lock);
            if (w_wr_out)   r_out  <= (r_out & r_lock) | (w_wd & ~r_lock);
            if (w_lock_set) r_lock <= r_lock | w_wd;
            // A new error outranks a simultaneous W1C of VIOL
            if (w_err) begin
                r_viol <= 1'b1;
                if (r_vcnt != 8'hFF) r_vcnt <= r_vcnt + 8'h01;
            end else if (w_wr_status && PWDATA[2]) begin
                r_viol <= 1'b0;
            end
        end
    end

    assign PRDATA    = w_rdata;
    assign PSLVERR   = w_err;
    assign PREADY    = 1'b1;
    assign gpio_out  = r_out;
    assign gpio_dir  = r_dir;
    assign gpio_lock = r_lock;

endmodule
